// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - keystroke collector assembling a BCD operation for the calculate block
//
// Accepts one ASCII key per key_valid/key_ready handshake and builds
// operand 1, an operator and operand 2. On '=' the complete operation is
// held stable with req high until req_ack is sampled.
//
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   key_valid, key_code - incoming ASCII key, held until accepted
//   key_ready           - block can accept a key (combinational)
//   reg_num1, cnt1      - operand 1 as packed BCD (ones digit in [3:0]) and digit count
//   sym                 - operator code (8'h61..8'h64), 0 when none
//   reg_num2, cnt2      - operand 2, same packing as operand 1
//   req, req_ack        - operation complete / consumer has taken it
//   ovf                 - sticky: a digit was dropped because the operand was full

module calc_key_entry #(
  parameter int MAX_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [7:0]              key_code,
  output logic                    key_ready,
  output logic [4*MAX_DIGITS-1:0] reg_num1,
  output logic [2:0]              cnt1,
  output logic [7:0]              sym,
  output logic [4*MAX_DIGITS-1:0] reg_num2,
  output logic [2:0]              cnt2,
  output logic                    req,
  input  logic                    req_ack,
  output logic                    ovf
);

  localparam int         W       = 4 * MAX_DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_REQ = 2'd2
  } state_t;

  state_t state;

  logic is_digit;
  logic is_op;
  logic is_eq;
  logic is_clr;

  assign is_digit = (key_code >= 8'h30) && (key_code <= 8'h39);
  assign is_op    = (key_code >= 8'h61) && (key_code <= 8'h64);
  assign is_eq    = (key_code == 8'h65);
  assign is_clr   = (key_code == 8'h1B);

  assign key_ready = !rst && (state != S_REQ);
  assign req       = (state == S_REQ);

  // Shift a new BCD digit into the ones position. Building the W+4 bit
  // concatenation and keeping the low W bits works for MAX_DIGITS = 1 too.
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] v, input logic [3:0] d);
    logic [W+3:0] t;
    t = {v, d};
    return t[W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_OP1;
      reg_num1 <= '0;
      reg_num2 <= '0;
      cnt1     <= '0;
      cnt2     <= '0;
      sym      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        S_OP1: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt1 < MAX_CNT) begin
                reg_num1 <= shift_in(reg_num1, key_code[3:0]);
                cnt1     <= cnt1 + 3'd1;
              end else begin
                ovf <= 1'b1;
              end
            end else if (is_op) begin
              // An operator with no operand 1 yet has nothing to apply to.
              if (cnt1 != 3'd0) begin
                sym   <= key_code;
                state <= S_OP2;
              end
            end else if (is_clr) begin
              reg_num1 <= '0;
              reg_num2 <= '0;
              cnt1     <= '0;
              cnt2     <= '0;
              sym      <= '0;
              ovf      <= 1'b0;
            end
          end
        end

        S_OP2: begin
          if (key_valid) begin
            if (is_digit) begin
              if (cnt2 < MAX_CNT) begin
                reg_num2 <= shift_in(reg_num2, key_code[3:0]);
                cnt2     <= cnt2 + 3'd1;
              end else begin
                ovf <= 1'b1;
              end
            end else if (is_op) begin
              // Until operand 2 starts, the most recent operator wins.
              if (cnt2 == 3'd0) begin
                sym <= key_code;
              end
            end else if (is_eq) begin
              if (cnt2 != 3'd0) begin
                state <= S_REQ;
              end
            end else if (is_clr) begin
              state    <= S_OP1;
              reg_num1 <= '0;
              reg_num2 <= '0;
              cnt1     <= '0;
              cnt2     <= '0;
              sym      <= '0;
              ovf      <= 1'b0;
            end
          end
        end

        S_REQ: begin
          if (req_ack) begin
            state    <= S_OP1;
            reg_num1 <= '0;
            reg_num2 <= '0;
            cnt1     <= '0;
            cnt2     <= '0;
            sym      <= '0;
            ovf      <= 1'b0;
          end
        end

        default: begin
          state <= S_OP1;
        end
      endcase
    end
  end

endmodule
